// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory BRAM port between the CPU MEM stage and a DMA requester.
// CPU wins by default; a starved DMA gets one forced cycle, and read data is steered to its owner.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WE_W       = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [WE_W-1:0]   cpu_wea,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [WE_W-1:0]   dma_wea,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [WE_W-1:0]   bram_wea,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e            rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] cap_q;
  logic              dma_win;
  logic              cpu_win;

  // Ownership is decided combinationally; nobody wins while reset is held.
  always_comb begin
    dma_win = reset && dma_req && (!cpu_req || (starve_q == CNT_MAX));
    cpu_win = reset && cpu_req && !dma_win;
  end

  // Port mux: the winner drives the BRAM, otherwise the last address/data are held.
  always_comb begin
    bram_addr = addr_q;
    bram_din  = din_q;
    bram_wea  = '0;
    if (cpu_win) begin
      bram_addr = cpu_addr;
      bram_din  = cpu_wdata;
      bram_wea  = cpu_wea;
    end else if (dma_win) begin
      bram_addr = dma_addr;
      bram_din  = dma_wdata;
      bram_wea  = dma_wea;
    end
    if (!reset) begin
      bram_addr = '0;
      bram_din  = '0;
    end
  end

  // Next read owner and starvation count.
  always_comb begin
    rd_owner_d = OWN_NONE;
    starve_d   = starve_q;
    if (cpu_win && (cpu_wea == '0)) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_win && (dma_wea == '0)) begin
      rd_owner_d = OWN_DMA;
    end
    if (dma_win) begin
      starve_d = '0;
    end else if (dma_req && (starve_q < CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_owner_q <= OWN_NONE;
      starve_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      cap_q      <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
      addr_q     <= bram_addr;
      din_q      <= bram_din;
      if (rd_owner_q == OWN_CPU) begin
        cap_q <= bram_dout;
      end
    end
  end

  // CPU sees live data only for its own read; otherwise the captured word.
  always_comb begin
    cpu_busy   = cpu_req && dma_win;
    dma_gnt    = dma_win;
    dma_rvalid = reset && (rd_owner_q == OWN_DMA);
    dma_rdata  = bram_dout;
    cpu_rdata  = (reset && (rd_owner_q == OWN_CPU)) ? bram_dout : cap_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a 1-cycle-latency BRAM model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wea;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        dma_req;
  logic [29:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wea;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [29:0] bram_addr;
  logic [31:0] bram_din;
  logic [3:0]  bram_wea;
  logic [31:0] bram_dout = 32'h0;

  logic [31:0] mem [256];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wea(cpu_wea),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wea(dma_wea),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_wea(bram_wea), .bram_dout(bram_dout)
  );

  // Read-first BRAM; preload happens while reset is held.
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'h12345678;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bram_wea[b]) mem[bram_addr[7:0]][b*8 +: 8] <= bram_din[b*8 +: 8];
    end
    bram_dout <= mem[bram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 30'h55; cpu_wdata = 32'hFFFF0000; cpu_wea = 4'hF;
    dma_req = 1'b1; dma_addr = 30'h55; dma_wdata = 32'h0000FFFF; dma_wea = 4'hF;

    // Reset with both requesters active
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wea", 32'(bram_wea), 32'h0);
    chk("rst_gnt", 32'(dma_gnt), 32'h0);
    chk("rst_busy", 32'(cpu_busy), 32'h0);
    chk("rst_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rst_addr", 32'(bram_addr), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);

    // CPU-only read of 0x10
    @(negedge clk);
    reset = 1'b1; dma_req = 1'b0;
    cpu_addr = 30'h10; cpu_wea = 4'h0;
    #1;
    chk("cpu_addr", 32'(bram_addr), 32'h10);
    chk("cpu_busy0", 32'(cpu_busy), 32'h0);
    chk("cpu_nognt", 32'(dma_gnt), 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("idle_hold_addr", 32'(bram_addr), 32'h10);
    chk("idle_wea", 32'(bram_wea), 32'h0);

    // DMA-only write then read of 0x20
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 30'h20; dma_wdata = 32'hA5A5A5A5; dma_wea = 4'hF;
    #1;
    chk("dma_wr_gnt", 32'(dma_gnt), 32'h1);
    chk("dma_wr_wea", 32'(bram_wea), 32'hF);
    chk("dma_wr_din", bram_din, 32'hA5A5A5A5);
    @(negedge clk);
    dma_wea = 4'h0;
    #1;
    chk("dma_rd_gnt", 32'(dma_gnt), 32'h1);
    chk("dma_wr_norv", 32'(dma_rvalid), 32'h0);
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    chk("dma_rvalid", 32'(dma_rvalid), 32'h1);
    chk("dma_rdata", dma_rdata, 32'hA5A5A5A5);
    chk("cpu_iso0", cpu_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("dma_rvalid_off", 32'(dma_rvalid), 32'h0);

    // Starvation pattern and read-data isolation
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 30'h10; cpu_wea = 4'h0;
    dma_req = 1'b1; dma_addr = 30'h30; dma_wea = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_gnt%0d", i), 32'(dma_gnt), 32'((i % 5) == 4));
      chk($sformatf("starve_busy%0d", i), 32'(cpu_busy), 32'((i % 5) == 4));
      if (i == 5) begin
        chk("iso_rvalid", 32'(dma_rvalid), 32'h1);
        chk("iso_dma_rdata", dma_rdata, 32'h12345678);
        chk("iso_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      end
      @(negedge clk);
    end

    // CPU write and DMA read of the same address
    cpu_addr = 30'h40; cpu_wdata = 32'h11112222; cpu_wea = 4'hF;
    dma_addr = 30'h40; dma_wea = 4'h0;
    #1;
    chk("wr_busy", 32'(cpu_busy), 32'h0);
    chk("wr_nognt", 32'(dma_gnt), 32'h0);
    chk("wr_wea", 32'(bram_wea), 32'hF);
    chk("wr_prev_rdata", dma_rdata, 32'h12345678);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("wr_dma_gnt", 32'(dma_gnt), 32'h1);
    chk("wr_dma_addr", 32'(bram_addr), 32'h40);
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    chk("wr_dma_rvalid", 32'(dma_rvalid), 32'h1);
    chk("wr_dma_rdata", dma_rdata, 32'h11112222);

    // Reset the cycle after a DMA read grant, with the counter raised beforehand
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 30'h10; cpu_wea = 4'h0;
    dma_req = 1'b1; dma_addr = 30'h30; dma_wea = 4'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pre_gnt%0d", i), 32'(dma_gnt), 32'h0);
      @(negedge clk);
    end
    cpu_req = 1'b0;
    #1;
    chk("pre_rd_gnt", 32'(dma_gnt), 32'h1);
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b1;
    #1;
    chk("mid_rvalid", 32'(dma_rvalid), 32'h0);
    chk("mid_gnt", 32'(dma_gnt), 32'h0);
    chk("mid_busy", 32'(cpu_busy), 32'h0);
    @(negedge clk);
    #1;
    chk("mid_cap", cpu_rdata, 32'h0);
    chk("mid_addr", 32'(bram_addr), 32'h0);
    chk("mid_rvalid2", 32'(dma_rvalid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("post_gnt%0d", i), 32'(dma_gnt), 32'(i == 4));
      chk($sformatf("post_busy%0d", i), 32'(cpu_busy), 32'(i == 4));
      if (i == 0) chk("post_rvalid", 32'(dma_rvalid), 32'h0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
